// File: rtl/dataio_arbiter.sv
// Two-port data access arbiter in front of a single memory port.
// One transaction in flight, one queued behind it; WAIT is bounded by a timeout.
module dataio_arbiter #(
    parameter int P_RR      = 1,
    parameter int P_TIMEOUT = 255
) (
    input  logic        iCLOCK,
    input  logic        iRESET_SYNC,
    input  logic        iREQ0,
    input  logic        iREQ1,
    output logic        oBUSY0,
    output logic        oBUSY1,
    input  logic [1:0]  iORDER0,
    input  logic [1:0]  iORDER1,
    input  logic [3:0]  iMASK0,
    input  logic [3:0]  iMASK1,
    input  logic        iRW0,
    input  logic        iRW1,
    input  logic [31:0] iADDR0,
    input  logic [31:0] iADDR1,
    input  logic [31:0] iDATA0,
    input  logic [31:0] iDATA1,
    output logic        oVALID0,
    output logic        oVALID1,
    output logic [31:0] oDATA0,
    output logic [31:0] oDATA1,
    output logic        oMEM_REQ,
    input  logic        iMEM_BUSY,
    output logic [1:0]  oMEM_ORDER,
    output logic [3:0]  oMEM_MASK,
    output logic        oMEM_RW,
    output logic [31:0] oMEM_ADDR,
    output logic [31:0] oMEM_DATA,
    input  logic        iMEM_VALID,
    input  logic [31:0] iMEM_DATA,
    output logic        oTIMEOUT
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    typedef struct packed {
        logic [1:0]  order;
        logic [3:0]  mask;
        logic        rw;
        logic [31:0] addr;
        logic [31:0] data;
    } pay_t;

    localparam logic [9:0] TO_LAST = 10'(P_TIMEOUT - 1);

    state_t      state_q, state_d;
    pay_t        act_pay_q, act_pay_d;
    pay_t        pend_pay_q, pend_pay_d;
    logic        act_own_q, act_own_d;
    logic        pend_own_q, pend_own_d;
    logic        pend_vld_q, pend_vld_d;
    logic [9:0]  cnt_q, cnt_d;
    logic        last_q, last_d;

    pay_t        pay0, pay1;
    logic        win;
    logic        done;
    logic        mem_req;
    logic        valid0, valid1;
    logic        tout;
    logic [31:0] resp_data;

    assign pay0 = {iORDER0, iMASK0, iRW0, iADDR0, iDATA0};
    assign pay1 = {iORDER1, iMASK1, iRW1, iADDR1, iDATA1};

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            state_q    <= IDLE;
            act_pay_q  <= '0;
            pend_pay_q <= '0;
            act_own_q  <= 1'b0;
            pend_own_q <= 1'b0;
            pend_vld_q <= 1'b0;
            cnt_q      <= '0;
            last_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            act_pay_q  <= act_pay_d;
            pend_pay_q <= pend_pay_d;
            act_own_q  <= act_own_d;
            pend_own_q <= pend_own_d;
            pend_vld_q <= pend_vld_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        act_pay_d  = act_pay_q;
        pend_pay_d = pend_pay_q;
        act_own_d  = act_own_q;
        pend_own_d = pend_own_q;
        pend_vld_d = pend_vld_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        win        = 1'b0;
        done       = 1'b0;
        mem_req    = 1'b0;
        valid0     = 1'b0;
        valid1     = 1'b0;
        tout       = 1'b0;
        resp_data  = '0;
        unique case (state_q)
            IDLE: begin
                if (iREQ0 && iREQ1) begin
                    win        = (P_RR != 0) ? ~last_q : 1'b0;
                    act_own_d  = win;
                    act_pay_d  = win ? pay1 : pay0;
                    pend_own_d = ~win;
                    pend_pay_d = win ? pay0 : pay1;
                    pend_vld_d = 1'b1;
                    last_d     = win;
                    state_d    = ISSUE;
                end else if (iREQ0) begin
                    act_own_d = 1'b0;
                    act_pay_d = pay0;
                    last_d    = 1'b0;
                    state_d   = ISSUE;
                end else if (iREQ1) begin
                    act_own_d = 1'b1;
                    act_pay_d = pay1;
                    last_d    = 1'b1;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                mem_req = !iMEM_BUSY;
                if (!iMEM_BUSY) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                // A response in the last allowed cycle wins over the abort
                if (iMEM_VALID) begin
                    done      = 1'b1;
                    resp_data = iMEM_DATA;
                end else if (cnt_q == TO_LAST) begin
                    done = 1'b1;
                    tout = 1'b1;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
                if (done) begin
                    valid0 = !act_own_q;
                    valid1 = act_own_q;
                    if (pend_vld_q) begin
                        act_own_d  = pend_own_q;
                        act_pay_d  = pend_pay_q;
                        pend_vld_d = 1'b0;
                        last_d     = pend_own_q;
                        state_d    = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign oBUSY0     = (state_q != IDLE) || pend_vld_q;
    assign oBUSY1     = (state_q != IDLE) || pend_vld_q;
    assign oMEM_REQ   = mem_req;
    assign oMEM_ORDER = act_pay_q.order;
    assign oMEM_MASK  = act_pay_q.mask;
    assign oMEM_RW    = act_pay_q.rw;
    assign oMEM_ADDR  = act_pay_q.addr;
    assign oMEM_DATA  = act_pay_q.data;
    assign oVALID0    = valid0;
    assign oVALID1    = valid1;
    assign oDATA0     = valid0 ? resp_data : 32'h0;
    assign oDATA1     = valid1 ? resp_data : 32'h0;
    assign oTIMEOUT   = tout;

endmodule

// File: tb/tb_dataio_arbiter.sv
// Bench for dataio_arbiter: directed scenarios plus a random run
// checked against a transaction-queue reference model.
module tb_dataio_arbiter;

    localparam int RR = 1;
    localparam int TO = 8;

    logic        iCLOCK;
    logic        iRESET_SYNC;
    logic        iREQ0, iREQ1;
    logic        oBUSY0, oBUSY1;
    logic [1:0]  iORDER0, iORDER1;
    logic [3:0]  iMASK0, iMASK1;
    logic        iRW0, iRW1;
    logic [31:0] iADDR0, iADDR1;
    logic [31:0] iDATA0, iDATA1;
    logic        oVALID0, oVALID1;
    logic [31:0] oDATA0, oDATA1;
    logic        oMEM_REQ;
    logic        iMEM_BUSY;
    logic [1:0]  oMEM_ORDER;
    logic [3:0]  oMEM_MASK;
    logic        oMEM_RW;
    logic [31:0] oMEM_ADDR;
    logic [31:0] oMEM_DATA;
    logic        iMEM_VALID;
    logic [31:0] iMEM_DATA;
    logic        oTIMEOUT;

    int vectors = 0;
    int errors  = 0;

    dataio_arbiter #(.P_RR(RR), .P_TIMEOUT(TO)) dut (
        .iCLOCK(iCLOCK), .iRESET_SYNC(iRESET_SYNC),
        .iREQ0(iREQ0), .iREQ1(iREQ1),
        .oBUSY0(oBUSY0), .oBUSY1(oBUSY1),
        .iORDER0(iORDER0), .iORDER1(iORDER1),
        .iMASK0(iMASK0), .iMASK1(iMASK1),
        .iRW0(iRW0), .iRW1(iRW1),
        .iADDR0(iADDR0), .iADDR1(iADDR1),
        .iDATA0(iDATA0), .iDATA1(iDATA1),
        .oVALID0(oVALID0), .oVALID1(oVALID1),
        .oDATA0(oDATA0), .oDATA1(oDATA1),
        .oMEM_REQ(oMEM_REQ), .iMEM_BUSY(iMEM_BUSY),
        .oMEM_ORDER(oMEM_ORDER), .oMEM_MASK(oMEM_MASK),
        .oMEM_RW(oMEM_RW), .oMEM_ADDR(oMEM_ADDR),
        .oMEM_DATA(oMEM_DATA),
        .iMEM_VALID(iMEM_VALID), .iMEM_DATA(iMEM_DATA),
        .oTIMEOUT(oTIMEOUT)
    );

    initial iCLOCK = 1'b0;
    always #5 iCLOCK = ~iCLOCK;

    typedef struct {
        bit          own;
        logic [1:0]  order;
        logic [3:0]  mask;
        logic        rw;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    // Reference model: FIFO of accepted transactions, head is in flight
    txn_t q[$];
    txn_t cur;
    bit   sent;
    int   waited;
    bit   last;

    task automatic model_reset();
        q.delete();
        cur    = '{default: 0};
        sent   = 1'b0;
        waited = 0;
        last   = 1'b1;
    endtask

    task automatic idle_inputs();
        iRESET_SYNC = 0; iREQ0 = 0; iREQ1 = 0;
        iORDER0 = 0; iORDER1 = 0; iMASK0 = 0; iMASK1 = 0;
        iRW0 = 0; iRW1 = 0; iADDR0 = 0; iADDR1 = 0;
        iDATA0 = 0; iDATA1 = 0; iMEM_BUSY = 0;
        iMEM_VALID = 0; iMEM_DATA = 0;
    endtask

    task automatic step_cycle();
        @(posedge iCLOCK);
        @(negedge iCLOCK);
    endtask

    task automatic do_reset();
        iRESET_SYNC = 1;
        step_cycle();
        iRESET_SYNC = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        iRESET_SYNC = 1;
        @(negedge iCLOCK);
        step_cycle();
        #1;
        vectors++;
        if ({oBUSY0, oBUSY1, oMEM_REQ, oVALID0, oVALID1, oTIMEOUT} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b want 000000",
                {oBUSY0, oBUSY1, oMEM_REQ, oVALID0, oVALID1, oTIMEOUT});
        end
        vectors++;
        if ({oMEM_ADDR, oMEM_DATA, oDATA0, oDATA1} !== 128'h0) begin
            errors++; $display("FAIL reset_data: got %h want 0",
                {oMEM_ADDR, oMEM_DATA, oDATA0, oDATA1});
        end
        iRESET_SYNC = 0;
        step_cycle();
        #1;
        vectors++;
        if ({oBUSY0, oBUSY1, oMEM_REQ, oMEM_ORDER, oMEM_MASK, oMEM_RW} !== 10'b0) begin
            errors++; $display("FAIL post_reset: got %b want 0",
                {oBUSY0, oBUSY1, oMEM_REQ, oMEM_ORDER, oMEM_MASK, oMEM_RW});
        end
    endtask

    task automatic test_single_load();
        idle_inputs();
        do_reset();
        iREQ0 = 1; iADDR0 = 32'h100; iORDER0 = 2'b10; iMASK0 = 4'hF;
        #1;
        vectors++;
        if (oBUSY0 !== 1'b0) begin
            errors++; $display("FAIL load_idle_busy: got %b want 0", oBUSY0);
        end
        step_cycle();
        iREQ0 = 0;
        #1;
        vectors++;
        if ({oMEM_REQ, oBUSY0} !== 2'b11) begin
            errors++; $display("FAIL load_issue: got %b want 11", {oMEM_REQ, oBUSY0});
        end
        vectors++;
        if (oMEM_ADDR !== 32'h100) begin
            errors++; $display("FAIL load_addr: got %h want 00000100", oMEM_ADDR);
        end
        step_cycle();
        #1;
        vectors++;
        if (oMEM_REQ !== 1'b0) begin
            errors++; $display("FAIL load_wait_req: got %b want 0", oMEM_REQ);
        end
        step_cycle();
        step_cycle();
        iMEM_VALID = 1; iMEM_DATA = 32'hDEADBEEF;
        #1;
        vectors++;
        if ({oVALID0, oVALID1, oDATA0} !== {2'b10, 32'hDEADBEEF}) begin
            errors++; $display("FAIL load_resp: got %b %b %h want 1 0 deadbeef",
                oVALID0, oVALID1, oDATA0);
        end
        step_cycle();
        iMEM_VALID = 0;
        #1;
        vectors++;
        if ({oBUSY0, oVALID0, oDATA0} !== 34'h0) begin
            errors++; $display("FAIL load_done: got %b %b %h want 0 0 0",
                oBUSY0, oVALID0, oDATA0);
        end
        iMEM_VALID = 1; iMEM_DATA = 32'h5555AAAA;
        #1;
        vectors++;
        if ({oVALID0, oVALID1, oDATA0, oDATA1} !== 66'h0) begin
            errors++; $display("FAIL stray_valid: got %b %b want 0 0", oVALID0, oVALID1);
        end
        step_cycle();
        iMEM_VALID = 0;
    endtask

    task automatic test_simultaneous();
        logic [31:0] a0[3] = '{32'h10, 32'h30, 32'h60};
        logic [31:0] a1[3] = '{32'h20, 32'h40, 32'h70};
        bit          first[3] = '{1'b0, 1'b0, 1'b1};
        idle_inputs();
        do_reset();
        for (int r = 0; r < 3; r++) begin
            if (r == 2) begin
                iREQ0 = 1; iADDR0 = 32'h50;
                step_cycle();
                iREQ0 = 0;
                step_cycle();
                iMEM_VALID = 1;
                step_cycle();
                iMEM_VALID = 0;
            end
            iREQ0 = 1; iADDR0 = a0[r];
            iREQ1 = 1; iADDR1 = a1[r];
            step_cycle();
            iREQ0 = 0; iREQ1 = 0;
            for (int k = 0; k < 2; k++) begin
                logic own;
                logic [31:0] ea;
                own = (k == 0) ? first[r] : !first[r];
                ea  = own ? a1[r] : a0[r];
                #1;
                vectors++;
                if ({oMEM_REQ, oBUSY0, oBUSY1, oMEM_ADDR} !== {3'b111, ea}) begin
                    errors++; $display("FAIL sim_issue r%0d k%0d: got %b %h want 111 %h",
                        r, k, {oMEM_REQ, oBUSY0, oBUSY1}, oMEM_ADDR, ea);
                end
                step_cycle();
                iMEM_VALID = 1; iMEM_DATA = 32'hA5A50000 | 32'(r * 2 + k);
                #1;
                vectors++;
                if ({oVALID1, oVALID0} !== (own ? 2'b10 : 2'b01) ||
                    (own ? oDATA1 : oDATA0) !== iMEM_DATA) begin
                    errors++; $display("FAIL sim_resp r%0d k%0d: got %b %h %h want owner %0d",
                        r, k, {oVALID1, oVALID0}, oDATA0, oDATA1, own);
                end
                step_cycle();
                iMEM_VALID = 0;
            end
            #1;
            vectors++;
            if ({oBUSY0, oBUSY1} !== 2'b00) begin
                errors++; $display("FAIL sim_idle r%0d: got %b want 00", r, {oBUSY0, oBUSY1});
            end
        end
    endtask

    task automatic test_mem_busy();
        int pulses = 0;
        idle_inputs();
        iREQ1 = 1; iADDR1 = 32'h55;
        step_cycle();
        iREQ1 = 0; iADDR1 = 32'h99; iMEM_BUSY = 1;
        for (int k = 0; k < 3; k++) begin
            #1;
            if (oMEM_REQ) pulses++;
            vectors++;
            if ({oMEM_REQ, oMEM_ADDR} !== {1'b0, 32'h55}) begin
                errors++; $display("FAIL busy_hold k%0d: got %b %h want 0 00000055",
                    k, oMEM_REQ, oMEM_ADDR);
            end
            step_cycle();
        end
        iMEM_BUSY = 0;
        #1;
        if (oMEM_REQ) pulses++;
        vectors++;
        if (oMEM_ADDR !== 32'h55) begin
            errors++; $display("FAIL busy_addr: got %h want 00000055", oMEM_ADDR);
        end
        step_cycle();
        #1;
        if (oMEM_REQ) pulses++;
        vectors++;
        if (pulses !== 1) begin
            errors++; $display("FAIL busy_pulses: got %0d want 1", pulses);
        end
        iMEM_VALID = 1; iMEM_DATA = 32'h0BADF00D;
        #1;
        vectors++;
        if ({oVALID1, oDATA1} !== {1'b1, 32'h0BADF00D}) begin
            errors++; $display("FAIL busy_resp: got %b %h want 1 0badf00d", oVALID1, oDATA1);
        end
        step_cycle();
        iMEM_VALID = 0;
    endtask

    task automatic test_timeout();
        idle_inputs();
        iREQ1 = 1; iADDR1 = 32'h77;
        step_cycle();
        iREQ1 = 0;
        step_cycle();
        for (int w = 1; w <= 8; w++) begin
            iMEM_DATA = $urandom | 32'h1;
            #1;
            vectors++;
            if (w < 8) begin
                if ({oTIMEOUT, oVALID1, oVALID0} !== 3'b000) begin
                    errors++; $display("FAIL to_early w%0d: got %b want 000",
                        w, {oTIMEOUT, oVALID1, oVALID0});
                end
            end else begin
                if ({oTIMEOUT, oVALID1, oVALID0, oDATA1} !== {3'b110, 32'h0}) begin
                    errors++; $display("FAIL to_fire: got %b %h want 110 0",
                        {oTIMEOUT, oVALID1, oVALID0}, oDATA1);
                end
            end
            step_cycle();
        end
        #1;
        vectors++;
        if ({oBUSY1, oTIMEOUT, oVALID1} !== 3'b000) begin
            errors++; $display("FAIL to_after: got %b want 000", {oBUSY1, oTIMEOUT, oVALID1});
        end
        iREQ1 = 1;
        step_cycle();
        iREQ1 = 0;
        step_cycle();
        for (int w = 1; w < 8; w++) step_cycle();
        iMEM_VALID = 1; iMEM_DATA = 32'hCAFE0001;
        #1;
        vectors++;
        if ({oTIMEOUT, oVALID1, oDATA1} !== {2'b01, 32'hCAFE0001}) begin
            errors++; $display("FAIL to_race: got %b %b %h want 0 1 cafe0001",
                oTIMEOUT, oVALID1, oDATA1);
        end
        step_cycle();
        iMEM_VALID = 0;
    endtask

    task automatic test_reset_mid_wait();
        idle_inputs();
        iREQ0 = 1; iADDR0 = 32'h300;
        step_cycle();
        iREQ0 = 0;
        step_cycle();
        iRESET_SYNC = 1;
        step_cycle();
        iRESET_SYNC = 0;
        #1;
        vectors++;
        if ({oBUSY0, oBUSY1, oMEM_REQ, oMEM_ADDR} !== 35'h0) begin
            errors++; $display("FAIL rst_wait_state: got %b %h want 000 0",
                {oBUSY0, oBUSY1, oMEM_REQ}, oMEM_ADDR);
        end
        step_cycle();
        iMEM_VALID = 1; iMEM_DATA = 32'h1234;
        #1;
        vectors++;
        if ({oVALID0, oVALID1, oTIMEOUT, oDATA0} !== 35'h0) begin
            errors++; $display("FAIL rst_wait_resp: got %b %h want 000 0",
                {oVALID0, oVALID1, oTIMEOUT}, oDATA0);
        end
        step_cycle();
        iMEM_VALID = 0;
    endtask

    task automatic test_write();
        idle_inputs();
        iREQ1 = 1; iRW1 = 1; iDATA1 = 32'h12345678;
        iMASK1 = 4'hF; iORDER1 = 2'b10; iADDR1 = 32'h400;
        step_cycle();
        iREQ1 = 0; iRW1 = 0; iDATA1 = 32'h0; iMASK1 = 4'h0;
        #1;
        vectors++;
        if ({oMEM_REQ, oMEM_RW, oMEM_MASK, oMEM_ORDER, oMEM_DATA} !==
            {2'b11, 4'hF, 2'b10, 32'h12345678}) begin
            errors++; $display("FAIL wr_issue: got %b %b %h %b %h want 1 1 f 10 12345678",
                oMEM_REQ, oMEM_RW, oMEM_MASK, oMEM_ORDER, oMEM_DATA);
        end
        step_cycle();
        iMEM_VALID = 1;
        #1;
        vectors++;
        if ({oVALID1, oVALID0} !== 2'b10) begin
            errors++; $display("FAIL wr_ack: got %b want 10", {oVALID1, oVALID0});
        end
        step_cycle();
        iMEM_VALID = 0;
        #1;
        vectors++;
        if ({oVALID1, oBUSY1} !== 2'b00) begin
            errors++; $display("FAIL wr_done: got %b want 00", {oVALID1, oBUSY1});
        end
    endtask

    task automatic test_random(int n);
        txn_t        t0, t1;
        bit          resp, etout, ereq, ebusy;
        bit [1:0]    ev;
        logic [31:0] ed0, ed1;
        idle_inputs();
        do_reset();
        model_reset();
        for (int i = 0; i < n; i++) begin
            iREQ0 = ($urandom_range(0, 2) == 0);
            iREQ1 = ($urandom_range(0, 2) == 0);
            iORDER0 = 2'($urandom_range(0, 2)); iORDER1 = 2'($urandom_range(0, 2));
            iMASK0 = 4'($urandom); iMASK1 = 4'($urandom);
            iRW0 = 1'($urandom); iRW1 = 1'($urandom);
            iADDR0 = $urandom; iADDR1 = $urandom;
            iDATA0 = $urandom; iDATA1 = $urandom;
            iMEM_BUSY = ($urandom_range(0, 2) == 0);
            iMEM_VALID = ($urandom_range(0, 3) == 0);
            iMEM_DATA = $urandom;
            iRESET_SYNC = ($urandom_range(0, 199) == 0);
            #1;
            ebusy = (q.size() != 0);
            ereq  = ebusy && !sent && !iMEM_BUSY;
            resp = 0; etout = 0; ev = 0; ed0 = 0; ed1 = 0;
            if (ebusy && sent) begin
                if (iMEM_VALID) resp = 1;
                else if (waited == TO - 1) begin resp = 1; etout = 1; end
                if (resp) begin
                    if (q[0].own) begin ev = 2'b10; ed1 = etout ? 32'h0 : iMEM_DATA; end
                    else begin ev = 2'b01; ed0 = etout ? 32'h0 : iMEM_DATA; end
                end
            end
            vectors++;
            if ({oBUSY1, oBUSY0, oMEM_REQ, oTIMEOUT} !== {ebusy, ebusy, ereq, etout}) begin
                errors++; $display("FAIL rnd_ctrl c%0d: got %b want %b", i,
                    {oBUSY1, oBUSY0, oMEM_REQ, oTIMEOUT}, {ebusy, ebusy, ereq, etout});
            end
            vectors++;
            if ({oMEM_ORDER, oMEM_MASK, oMEM_RW, oMEM_ADDR, oMEM_DATA} !==
                {cur.order, cur.mask, cur.rw, cur.addr, cur.data}) begin
                errors++; $display("FAIL rnd_payload c%0d: got %h want %h", i,
                    {oMEM_ORDER, oMEM_MASK, oMEM_RW, oMEM_ADDR, oMEM_DATA},
                    {cur.order, cur.mask, cur.rw, cur.addr, cur.data});
            end
            vectors++;
            if ({oVALID1, oVALID0, oDATA1, oDATA0} !== {ev, ed1, ed0}) begin
                errors++; $display("FAIL rnd_resp c%0d: got %b %h %h want %b %h %h", i,
                    {oVALID1, oVALID0}, oDATA1, oDATA0, ev, ed1, ed0);
            end
            @(posedge iCLOCK);
            if (iRESET_SYNC) begin
                model_reset();
            end else if (!ebusy) begin
                t0 = '{1'b0, iORDER0, iMASK0, iRW0, iADDR0, iDATA0};
                t1 = '{1'b1, iORDER1, iMASK1, iRW1, iADDR1, iDATA1};
                if (iREQ0 && iREQ1) begin
                    if (RR != 0 && last == 1'b0) begin q.push_back(t1); q.push_back(t0); end
                    else begin q.push_back(t0); q.push_back(t1); end
                end else if (iREQ0) q.push_back(t0);
                else if (iREQ1) q.push_back(t1);
                if (q.size() != 0) begin cur = q[0]; last = q[0].own; sent = 0; end
            end else if (!sent) begin
                if (!iMEM_BUSY) begin sent = 1; waited = 0; end
            end else if (resp) begin
                void'(q.pop_front());
                if (q.size() != 0) begin cur = q[0]; last = q[0].own; sent = 0; end
            end else begin
                waited++;
            end
            @(negedge iCLOCK);
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_simultaneous();
        test_mem_busy();
        test_timeout();
        test_reset_mid_wait();
        test_write();
        test_random(3000);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
